inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 108 ++++++++++
 tb/tb_inst_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and dispatch: circular buffer with
// a registered count, flushed by decoder redirects and ROB mispredicts.
module inst_queue #(
  parameter int DEPTH        = 16,
  parameter int IDWidth      = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_full_out,
  input  logic                    dispatcher_instqueue_rdy_in,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out,
  input  logic                    decoder_instqueue_rst_in,
  input  logic                    rob_instqueue_rst_in,
  output logic [$clog2(DEPTH):0]  instqueue_count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [IDWidth-1:0]      inst_mem_q [DEPTH];
  logic [AddressWidth-1:0] pc_mem_q   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;

  logic flush;
  logic pop;
  logic push;

  assign flush = decoder_instqueue_rst_in
               | rob_instqueue_rst_in;

  // Decoder flush is deliberately absent here: it is a function of en_out.
  assign pop = rdy_in
            && (count_q != '0)
            && dispatcher_instqueue_rdy_in
            && !rob_instqueue_rst_in;

  // Full check uses the pre-pop count, so a push into a full queue drops.
  assign push = rdy_in
             && if_instqueue_en_in
             && (count_q != FullCnt)
             && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (flush) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (pop) begin
          head_d = head_q + PW'(1);
        end
        if (push) begin
          tail_d = tail_q + PW'(1);
        end
        unique case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
    full_d = (count_d == FullCnt);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem_q[tail_q] <= if_instqueue_inst_in;
      pc_mem_q[tail_q]   <= if_instqueue_pc_in;
    end
  end

  assign instqueue_decoder_en_out   = pop;
  assign instqueue_decoder_inst_out = inst_mem_q[head_q];
  assign instqueue_decoder_pc_out   = pc_mem_q[head_q];
  assign instqueue_if_full_out      = full_q;
  assign instqueue_count_out        = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted pushes are queued and
// compared in order whenever the queue presents an entry.
module tb_inst_queue;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        f_en;
  logic [31:0] f_inst;
  logic [31:0] f_pc;
  logic        full;
  logic        d_rdy;
  logic        en;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        dec_rst;
  logic        rob_rst;
  logic [4:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t sb[$];
  int   n_cmp;
  int   n_bad;

  inst_queue #(
    .DEPTH(16),
    .IDWidth(32),
    .AddressWidth(32)
  ) dut (
    .clk_in                     (clk),
    .rst_n_in                   (rst_n),
    .rdy_in                     (rdy),
    .if_instqueue_en_in         (f_en),
    .if_instqueue_inst_in       (f_inst),
    .if_instqueue_pc_in         (f_pc),
    .instqueue_if_full_out      (full),
    .dispatcher_instqueue_rdy_in(d_rdy),
    .instqueue_decoder_en_out   (en),
    .instqueue_decoder_inst_out (inst_out),
    .instqueue_decoder_pc_out   (pc_out),
    .decoder_instqueue_rst_in   (dec_rst),
    .rob_instqueue_rst_in       (rob_rst),
    .instqueue_count_out        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_006F;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+1, check at negedge, update model after edge.
  task automatic cyc(input logic r, input logic f,
                     input logic [31:0] pc, input logic dr,
                     input logic dec, input logic rob);
    logic exp_en;
    logic acc;
    ent_t e;
    rdy     = r;
    f_en    = f;
    f_pc    = pc;
    f_inst  = mk_inst(pc);
    d_rdy   = dr;
    dec_rst = dec;
    rob_rst = rob;
    @(negedge clk);
    exp_en = r && (sb.size() != 0) && dr && !rob;
    acc    = r && f && (sb.size() < 16) && !(dec || rob);
    check("count", 64'(count), 64'(sb.size()));
    check("full", 64'(full), 64'(sb.size() == 16));
    check("en", 64'(en), 64'(exp_en));
    if (exp_en) begin
      e = sb.pop_front();
      check("pc", 64'(pc_out), 64'(e.pc));
      check("inst", 64'(inst_out), 64'(e.inst));
    end
    @(posedge clk);
    #1;
    if (r) begin
      if (dec || rob) begin
        sb.delete();
      end else if (acc) begin
        e.pc   = pc;
        e.inst = mk_inst(pc);
        sb.push_back(e);
      end
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, base + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    rdy     = 1'b1;
    f_en    = 1'b0;
    f_pc    = '0;
    f_inst  = '0;
    d_rdy   = 1'b1;
    dec_rst = 1'b0;
    rob_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_en", 64'(en), 64'd0);
    rst_n = 1'b1;

    // Three entries held, then released in order.
    fill(32'h0, 3);
    drain(3);
    idle();

    // Fill to full; extra pushes are dropped even alongside a pop.
    fill(32'h0, 17);
    cyc(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    drain(16);
    idle();

    // Steady state at count 5 with pointers wrapping.
    fill(32'h100, 5);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
    end
    drain(5);
    idle();

    // Decoder redirect: head consumed, same-cycle push discarded.
    fill(32'h300, 4);
    cyc(1'b1, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0);
    idle();

    // ROB flush suppresses the pop and clears the queue.
    fill(32'h500, 3);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle();

    // Global stall freezes state, ignoring pushes and flushes.
    fill(32'h600, 2);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 32'h700 + 32'(i * 4), 1'b1, i == 2, i == 4);
    end
    drain(3);

    // Asynchronous reset mid-stream, between clock edges.
    fill(32'h800, 3);
    d_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_en", 64'(en), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    fill(32'h900, 2);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
